rca_operand_loader: RTL
=======================

# rca_operand_loader

Upstream feeder for the 4-bit ripple-carry adder. It receives operands A and B as a serial bit stream and assembles them into parallel bits. It presents them to the adder on `a1..a4` / `b1..b4`, waits a fixed settle interval, then captures the adder outputs `s1..s4`, `c4` into a 5-bit result with a valid/ready handshake. All adder-facing outputs are registered and change only at operand-commit edges, so the combinational adder always sees stable inputs.

## Interface
- `SETTLE`, default 1: cycles between the operand commit and result capture; legal range 1..15.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous reset, active-high.
- `ser_in` in 1: serial operand bit.
- `ser_valid` in 1: `ser_in` is valid this cycle.
- `ser_ready` out 1: loader accepts a bit this cycle.
- `a1`, `a2`, `a3`, `a4` out 1 each: operand A to the adder; `a1` is the LSB.
- `b1`, `b2`, `b3`, `b4` out 1 each: operand B to the adder; `b1` is the LSB.
- `s1`, `s2`, `s3`, `s4` in 1 each: sum bits from the adder.
- `c4` in 1: carry-out from the adder.
- `res` out 5: captured result `{c4,s4,s3,s2,s1}`.
- `res_valid` out 1: `res` holds a new result.
- `res_ready` in 1: consumer accepts `res`.
- `busy` out 1: high in any state other than LOAD with bit count 0.

## Operation
- **FSM states:** LOAD, SETTLE_WAIT, HOLD.
- **LOAD**
  - `ser_ready`=1.
  - Each edge with `ser_valid`&&`ser_ready` consumes one bit into an internal 8-bit shadow register and increments a 3-bit bit counter.
  - Bit order: bits 0..3 map to A LSB-first (`a1`..`a4`); bits 4..7 map to B LSB-first (`b1`..`b4`).
  - `ser_valid` gaps are allowed; the counter holds.
- **Commit (8th accepted bit)**
  - On that edge, the assembled shadow is copied to `a1..a4`/`b1..b4` in one step.
  - Bit counter clears, a settle counter loads `SETTLE`-1, and the FSM goes to SETTLE_WAIT.
- **SETTLE_WAIT**
  - `ser_ready`=0.
  - Settle counter decrements each cycle.
  - On the edge where it reads 0: `res` <= `{c4,s4,s3,s2,s1}`, `res_valid` <= 1, FSM goes to HOLD.
- **HOLD**
  - `ser_ready`=0; `res` and `res_valid` are stable.
  - On the edge with `res_valid`&&`res_ready`: `res_valid` <= 0, FSM goes to LOAD.
- **Operand hold:** `a*`/`b*` keep the last committed operands until the next commit. A partial load never disturbs them.
- **Ignored input:** `ser_valid` while `ser_ready`=0 is ignored; no bit is consumed.
- **Reset:** `rst` high at any edge, including mid-load, SETTLE_WAIT or HOLD, does all of the following:
  - FSM <= LOAD; bit and settle counters <= 0; shadow <= 0.
  - `a1..a4`, `b1..b4` <= 0.
  - `res` <= 0, `res_valid` <= 0.
  - Partial operands are discarded.
- **Output decode:** `ser_ready` and `busy` are registered decodes of the next state. Both are 0 in the cycle after a reset edge is applied with `rst` still high. `ser_ready` becomes 1 on the first edge with `rst` low.

## Timing
- **Reset values:**
  - `ser_ready`=0, `busy`=0.
  - `a1..a4`, `b1..b4` = 0.
  - `res`=0, `res_valid`=0.
- **Bit accept:** one bit per cycle maximum; 8 accepts minimum per operation.
- **Commit edge E (8th accept):**
  - Operands appear at E.
  - `ser_ready` falls at E.
  - `res_valid` rises at E+`SETTLE`.
  - The sample uses adder outputs from `SETTLE` cycles of stable inputs.
- **Return to LOAD:** `ser_ready` rises at the same edge that `res_valid` falls.
- **Throughput:** with `ser_valid` and `res_ready` held high, one result every 8+`SETTLE`+1 cycles. `res_valid` pulses for exactly 1 cycle.
- **Backpressure:** `res_ready`=0 holds HOLD indefinitely; `res`, `a*`, `b*` stay stable.
- **No overlap:** loading of the next operand pair does not overlap SETTLE_WAIT or HOLD.

## Test plan
- **Basic add:** `SETTLE`=1, stream A=0101, B=0110 LSB-first (bits 1,0,1,0,0,1,1,0) against a correct adder model -> `a4..a1`=0101, `b4..b1`=0110 at E; `res`=01011 with `res_valid` at E+1; `ser_ready` high again the cycle after accept.
- **Carry-out:** A=1111, B=0001 -> `res`=10000. Then A=0000, B=0000 -> `res`=00000.
- **Gapped input:** `ser_valid` toggling 1,0,0,1,… while bits are held during gaps -> same `res` as contiguous input. `ser_valid` pulses during HOLD are not consumed.
- **Result backpressure:** `res_ready`=0 for 5 cycles after `res_valid` -> `res` and `a*`/`b*` stable for 5 cycles, `ser_ready`=0. Raising `res_ready` -> `res_valid` falls and `ser_ready` rises on the same edge.
- **Reset mid-load:** assert `rst` after 5 accepted bits -> all outputs 0. The next 8 bits (A=0011, B=0100) give `res`=00111, with no residue from the aborted load.
- **Settle latency:** `SETTLE`=3 -> `res_valid` exactly 3 cycles after commit edge E. Reset asserted during SETTLE_WAIT -> `res_valid` never rises.

Source files
------------

// File: rtl/rca_operand_loader.sv
// Serial-to-parallel operand feeder for the 4-bit ripple-carry adder.
// It commits A/B in one step, waits SETTLE cycles, then captures {c4,s4..s1}.
module rca_operand_loader #(
  parameter int unsigned SETTLE = 1  // 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       ser_valid,
  output logic       ser_ready,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       a4,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       b4,
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  input  logic       s4,
  input  logic       c4,
  output logic [4:0] res,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy
);

  typedef enum logic [1:0] {LOAD, SETTLE_WAIT, HOLD} state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [3:0] settle_cnt;
  logic [7:0] shadow;
  logic [3:0] a_q, b_q;
  logic       accept;

  assign accept = ser_valid && ser_ready;

  assign {a4, a3, a2, a1} = a_q;
  assign {b4, b3, b2, b1} = b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      shadow     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res        <= '0;
      res_valid  <= 1'b0;
      ser_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          ser_ready <= 1'b1;
          busy      <= accept || (bit_cnt != 3'd0);
          if (accept) begin
            shadow[bit_cnt] <= ser_in;
            bit_cnt         <= bit_cnt + 3'd1;  // wraps to 0 on the commit bit
            if (bit_cnt == 3'd7) begin
              // Last bit bypasses the shadow so operands update in one step.
              a_q        <= shadow[3:0];
              b_q        <= {ser_in, shadow[6:4]};
              settle_cnt <= 4'(SETTLE - 1);
              state      <= SETTLE_WAIT;
              ser_ready  <= 1'b0;
            end
          end
        end
        SETTLE_WAIT: begin
          if (settle_cnt == 4'd0) begin
            res       <= {c4, s4, s3, s2, s1};
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state     <= LOAD;
            ser_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
